ndp_stall_ctrl: RTL and testbench
=================================

Name: ndp_stall_ctrl

Overview:
- Upstream controller for the AXI channel gate: arbitrates near-data-processing (NDP) requests against host AW traffic.
- Raises stall_channel toward the gate and waits for the gate's ndp_not_inuse indication to fall, meaning the host write path is quiescent.
- Grants the NDP engine, waits for its completion, then releases the channel and waits for the gate to reopen.
- Provides a quiescence timeout with error reporting, plus grant and stall-cycle counters for software.

Parameters:
- SYNC_STAGES, 2, flops in the internal synchronizer on ndp_not_inuse_in (range 2-4).
- TIMEOUT_CYCLES, 1024, maximum cycles in WAIT_QUIET before abort; 0 disables the timeout.
- MIN_RELEASE, 4, minimum cycles stall_channel stays low in RELEASE before a new request is accepted.
- CNT_W, 32, width of stall_cycles.

Ports:
- clk_src  in  1  block clock; the stall_channel source domain.
- aresetn  in  1  synchronous, active-high reset; 1 = reset.
- ndp_req_valid  in  1  NDP engine requests the channel.
- ndp_req_ready  out  1  request accepted; high only in IDLE.
- ndp_done  in  1  one-cycle pulse from the NDP engine: operation finished.
- ndp_not_inuse_in  in  1  gate indication from the destination domain; asynchronous, synchronized internally.
- stall_channel  out  1  to the gate; registered.
- ndp_grant  out  1  NDP engine owns the channel; registered.
- ndp_busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse on quiescence timeout.
- grant_count  out  16  number of grants issued; wraps at 2^16.
- stall_cycles  out  CNT_W  cycles with stall_channel high; saturates at all-ones.

Behaviour:
- Reset (aresetn=1 at a clk_src edge):
  - State goes to IDLE.
  - stall_channel, ndp_grant, timeout_err, grant_count, stall_cycles and all synchronizer flops go to 0.
  - Reset mid-operation drops stall_channel and ndp_grant on the next edge; no release wait is performed.
- Synchronizer: q_sync is ndp_not_inuse_in after SYNC_STAGES flops. Every decision in this block uses q_sync only.
- FSM, all transitions on clk_src edges:
  - IDLE: ndp_req_ready=1. When ndp_req_valid=1 (handshake), go to WAIT_QUIET, set stall_channel=1, clear the timeout counter.
  - WAIT_QUIET:
    - When q_sync=0, go to GRANTED, set ndp_grant=1, increment grant_count.
    - Otherwise increment the timeout counter. If TIMEOUT_CYCLES≠0 and the count reaches TIMEOUT_CYCLES, pulse timeout_err, clear stall_channel, go to RELEASE. No grant is issued.
  - GRANTED: hold until ndp_done=1, then clear ndp_grant and stall_channel and go to RELEASE.
  - RELEASE:
    - Count cycles from entry.
    - Go to IDLE only when q_sync=1 AND at least MIN_RELEASE cycles have elapsed.
    - The exit condition is evaluated with no timeout.
- Latency, request to stall: ndp_req_valid sampled in IDLE gives stall_channel=1 on the next edge.
- Latency, grant: ndp_grant rises one cycle after q_sync is first seen low.
- Best-case request-to-grant: 1 + SYNC_STAGES + gate latency.
- ndp_done outside GRANTED is ignored. ndp_done is ignored on the same edge ndp_grant rises.
- A timeout and a q_sync fall in the same cycle: grant wins; no timeout_err.
- ndp_req_valid held high through RELEASE is accepted only after the return to IDLE. There is no back-to-back grant without a RELEASE.
- stall_cycles increments on every cycle in which the registered stall_channel=1, and saturates at all-ones.
- Invariants:
  - ndp_grant=1 implies stall_channel=1.
  - ndp_busy = (state≠IDLE).

Decomposition:
- Shared package ndp_pkg:
  - state encoding: IDLE=2'd0, WAIT_QUIET=2'd1, GRANTED=2'd2, RELEASE=2'd3;
  - default constants for TIMEOUT_CYCLES and MIN_RELEASE.
- One sub-module: ndp_sync_bit, a parameterized SYNC_STAGES flop chain with synchronous active-high reset. It is reused by other single-clock NDP blocks.

Test Plan:
- Nominal:
  - stimulus: pulse ndp_req_valid; the model drives ndp_not_inuse_in low 3 cycles after stall_channel rises; ndp_done 10 cycles after the grant; the model raises ndp_not_inuse_in 2 cycles after stall falls.
  - required: stall_channel rises at cycle 1; ndp_grant rises at 3+SYNC_STAGES+1; grant_count=1; back in IDLE after at least MIN_RELEASE cycles in RELEASE.
- Timeout:
  - stimulus: TIMEOUT_CYCLES=16; ndp_not_inuse_in held at 1.
  - required: exactly one timeout_err pulse 16 cycles into WAIT_QUIET; ndp_grant never 1; grant_count=0; stall_cycles=17.
- Slow reopen: ndp_not_inuse_in stays 0 for 50 cycles after release -> ndp_req_ready stays 0 until q_sync=1; a pending request is then accepted on the first IDLE cycle.
- Reset in GRANTED: assert aresetn for 1 cycle -> stall_channel=0, ndp_grant=0, counters=0 on the next edge; FSM in IDLE.
- Stray ndp_done pulses in IDLE and WAIT_QUIET -> no state change, no grant change.
- Saturation: preload or force stall_cycles to all-ones minus 1, then run 5 stalled cycles -> value holds at all-ones; grant_count wraps from 16'hFFFF to 0.

Source files
------------

// File: rtl/ndp_pkg.sv
// rtl/ndp_pkg.sv - shared state encoding and default timing constants for NDP blocks
package ndp_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_QUIET = 2'd1,
    GRANTED    = 2'd2,
    RELEASE    = 2'd3
  } ndp_state_t;

  localparam int NDP_TIMEOUT_CYCLES = 1024;
  localparam int NDP_MIN_RELEASE    = 4;

endpackage

// File: rtl/ndp_sync_bit.sv
// rtl/ndp_sync_bit.sv - single-bit flop-chain synchronizer with sync active-high reset
module ndp_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ndp_stall_ctrl.sv
// rtl/ndp_stall_ctrl.sv - NDP vs host arbitration: stall the gate, await quiescence, grant, release
module ndp_stall_ctrl
  import ndp_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = NDP_TIMEOUT_CYCLES,
  parameter int MIN_RELEASE    = NDP_MIN_RELEASE,
  parameter int CNT_W          = 32
) (
  input  logic             clk_src,
  input  logic             aresetn,
  input  logic             ndp_req_valid,
  output logic             ndp_req_ready,
  input  logic             ndp_done,
  input  logic             ndp_not_inuse_in,
  output logic             stall_channel,
  output logic             ndp_grant,
  output logic             ndp_busy,
  output logic             timeout_err,
  output logic [15:0]      grant_count,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int REL_W = (MIN_RELEASE > 1) ? $clog2(MIN_RELEASE + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [REL_W-1:0] REL_MIN   = REL_W'(MIN_RELEASE);

  ndp_state_t       r_state;
  logic             r_stall;
  logic             r_grant;
  logic             r_tmo_err;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [REL_W-1:0] r_rel_cnt;
  logic [15:0]      r_grant_count;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_q_sync;
  logic             w_tmo_hit;

  ndp_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk(clk_src),
    .i_rst(aresetn),
    .i_d  (ndp_not_inuse_in),
    .o_q  (w_q_sync)
  );

  // A zero limit disables the abort entirely.
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_tmo_cnt == TMO_LIMIT);

  always_ff @(posedge clk_src) begin
    if (aresetn) begin
      r_state       <= IDLE;
      r_stall       <= 1'b0;
      r_grant       <= 1'b0;
      r_tmo_err     <= 1'b0;
      r_tmo_cnt     <= '0;
      r_rel_cnt     <= '0;
      r_grant_count <= '0;
    end else begin
      r_tmo_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ndp_req_valid) begin
            r_state   <= WAIT_QUIET;
            r_stall   <= 1'b1;
            r_tmo_cnt <= '0;
          end
        end
        WAIT_QUIET: begin
          // Quiescence takes priority over an expiring timeout.
          if (!w_q_sync) begin
            r_state       <= GRANTED;
            r_grant       <= 1'b1;
            r_grant_count <= r_grant_count + 16'd1;
          end else if (w_tmo_hit) begin
            r_state   <= RELEASE;
            r_stall   <= 1'b0;
            r_tmo_err <= 1'b1;
            r_rel_cnt <= REL_W'(1);
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        GRANTED: begin
          if (ndp_done) begin
            r_state   <= RELEASE;
            r_grant   <= 1'b0;
            r_stall   <= 1'b0;
            r_rel_cnt <= REL_W'(1);
          end
        end
        RELEASE: begin
          // r_rel_cnt holds the number of cycles already spent with stall low.
          if (w_q_sync && (r_rel_cnt >= REL_MIN)) begin
            r_state <= IDLE;
          end else if (r_rel_cnt < REL_MIN) begin
            r_rel_cnt <= r_rel_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_src) begin
    if (aresetn) begin
      r_stall_cycles <= '0;
    end else if (r_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign ndp_req_ready = (r_state == IDLE);
  assign ndp_busy      = (r_state != IDLE);
  assign stall_channel = r_stall;
  assign ndp_grant     = r_grant;
  assign timeout_err   = r_tmo_err;
  assign grant_count   = r_grant_count;
  assign stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_ndp_stall_ctrl.sv
// tb/tb_ndp_stall_ctrl.sv - scoreboard bench for ndp_stall_ctrl with directed scenarios
module tb_ndp_stall_ctrl;

  localparam int SYNC = 2;
  localparam int TMO  = 16;
  localparam int MINR = 4;
  localparam int CW   = 32;

  localparam int EV_STALL = 0;
  localparam int EV_GRANT = 1;
  localparam int EV_TMO   = 2;
  localparam int EV_IDLE  = 3;

  typedef struct {
    int kind;
    int cyc;
    int gc;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          req   = 1'b0;
  logic          done  = 1'b0;
  logic          notin = 1'b1;
  logic          ready, stall, grant, busy, tmo;
  logic [15:0]   gcnt;
  logic [CW-1:0] scyc;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  logic p_stall, p_grant, p_busy;

  ndp_stall_ctrl #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO),
    .MIN_RELEASE   (MINR),
    .CNT_W         (CW)
  ) dut (
    .clk_src         (clk),
    .aresetn         (rst),
    .ndp_req_valid   (req),
    .ndp_req_ready   (ready),
    .ndp_done        (done),
    .ndp_not_inuse_in(notin),
    .stall_channel   (stall),
    .ndp_grant       (grant),
    .ndp_busy        (busy),
    .timeout_err     (tmo),
    .grant_count     (gcnt),
    .stall_cycles    (scyc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic expect_ev(input int k, input int c, input int g);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    e.gc   = g;
    sb_q.push_back(e);
  endtask

  task automatic ev(input int k);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL sb_unexpected kind=%0d cyc=%0d", k, cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.gc != int'(gcnt)) begin
        bad++;
        $display("FAIL sb_event got kind=%0d cyc=%0d gc=%0d exp kind=%0d cyc=%0d gc=%0d",
                 k, cyc, gcnt, e.kind, e.cyc, e.gc);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (stall && !p_stall) ev(EV_STALL);
      if (grant && !p_grant) ev(EV_GRANT);
      if (tmo) ev(EV_TMO);
      if (!busy && p_busy) ev(EV_IDLE);
      if (grant) check("grant_implies_stall", longint'(stall), 1);
      p_stall = stall;
      p_grant = grant;
      p_busy  = busy;
    end
  endtask

  // One full grant: quiet drop at +q, done at +d, reopen at +r (negedges after request).
  task automatic run_grant(input int q, input int d, input int r, input int g_prev);
    int b, g_new, idle_at;
    b       = cyc;
    g_new   = (g_prev + 1) % 65536;
    idle_at = (r + 3 > d + 5) ? r + 3 : d + 5;
    expect_ev(EV_STALL, b + 1, g_prev);
    expect_ev(EV_GRANT, b + q + 3, g_new);
    expect_ev(EV_IDLE, b + idle_at, g_new);
    req = 1'b1;
    tick(1);
    req = 1'b0;
    tick(q - 1);
    notin = 1'b0;
    tick(d - q);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    tick(r - d - 1);
    notin = 1'b1;
    tick(idle_at - r + 2);
  endtask

  initial begin
    int b;
    tick(3);
    rst = 1'b0;
    check("rst_stall", longint'(stall), 0);
    check("rst_grant", longint'(grant), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_ready", longint'(ready), 1);
    check("rst_tmo", longint'(tmo), 0);
    check("rst_gcnt", longint'(gcnt), 0);
    check("rst_scyc", longint'(scyc), 0);
    p_stall = stall;
    p_grant = grant;
    p_busy  = busy;
    fork
      monitor();
    join_none
    tick(4);

    // quiescence never arrives
    b = cyc;
    expect_ev(EV_STALL, b + 1, 0);
    expect_ev(EV_TMO, b + 18, 0);
    expect_ev(EV_IDLE, b + 22, 0);
    req = 1'b1;
    tick(1);
    req = 1'b0;
    tick(23);
    check("tmo_scyc", longint'(scyc), 17);
    check("tmo_gcnt", longint'(gcnt), 0);

    run_grant(3, 15, 17, 0);
    check("nom_scyc", longint'(scyc), 32);
    check("nom_gcnt", longint'(gcnt), 1);

    // stray done in IDLE, in WAIT_QUIET, and on the grant edge
    b = cyc;
    expect_ev(EV_STALL, b + 2, 1);
    expect_ev(EV_GRANT, b + 6, 2);
    expect_ev(EV_IDLE, b + 15, 2);
    done = 1'b1;
    tick(1);
    check("stray_idle_busy", longint'(busy), 0);
    done = 1'b0;
    req  = 1'b1;
    tick(1);
    req  = 1'b0;
    done = 1'b1;
    tick(1);
    done = 1'b0;
    check("stray_wq_stall", longint'(stall), 1);
    check("stray_wq_busy", longint'(busy), 1);
    notin = 1'b0;
    tick(2);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    tick(1);
    check("done_on_grant_edge", longint'(grant), 1);
    tick(3);
    done = 1'b1;
    tick(1);
    done  = 1'b0;
    notin = 1'b1;
    tick(5);
    check("stray_scyc", longint'(scyc), 41);

    // slow reopen with request held through RELEASE, then a timeout
    b = cyc;
    expect_ev(EV_STALL, b + 1, 2);
    expect_ev(EV_GRANT, b + 4, 3);
    expect_ev(EV_IDLE, b + 60, 3);
    expect_ev(EV_STALL, b + 61, 3);
    expect_ev(EV_TMO, b + 78, 3);
    expect_ev(EV_IDLE, b + 82, 3);
    req = 1'b1;
    tick(1);
    notin = 1'b0;
    tick(5);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    tick(23);
    check("slow_ready_mid", longint'(ready), 0);
    tick(27);
    notin = 1'b1;
    tick(2);
    check("slow_ready_pre_qsync", longint'(ready), 0);
    tick(1);
    check("slow_ready_idle", longint'(ready), 1);
    tick(1);
    req = 1'b0;
    tick(23);
    check("slow_scyc", longint'(scyc), 64);

    // counter saturation and wrap
    force dut.r_grant_count  = 16'hFFFF;
    force dut.r_stall_cycles = 32'hFFFF_FFFE;
    tick(1);
    release dut.r_grant_count;
    release dut.r_stall_cycles;
    tick(1);
    check("preload_gcnt", longint'(gcnt), 65535);
    run_grant(1, 8, 12, 65535);
    check("sat_scyc", longint'(scyc), longint'(32'hFFFF_FFFF));
    check("wrap_gcnt", longint'(gcnt), 0);

    // reset while GRANTED
    b = cyc;
    expect_ev(EV_STALL, b + 1, 0);
    expect_ev(EV_GRANT, b + 4, 1);
    expect_ev(EV_IDLE, b + 6, 0);
    req = 1'b1;
    tick(1);
    req   = 1'b0;
    notin = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("grst_stall", longint'(stall), 0);
    check("grst_grant", longint'(grant), 0);
    check("grst_gcnt", longint'(gcnt), 0);
    check("grst_scyc", longint'(scyc), 0);
    check("grst_ready", longint'(ready), 1);
    notin = 1'b1;
    tick(6);

    check("sb_drain", longint'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
